// File: rtl/chimera_cluster_pwr_seq_if.sv
// Handshake bundle between the host/cluster side and the cluster power sequencer.
//   en_req_i       : per-cluster requested power state (1 = on)
//   cluster_idle_i : per-cluster "no outstanding work" (gates power-down only)
//   clk_en_o       : per-cluster clock-gate enable
//   cluster_rst_no : per-cluster active-low reset
//   wake_o         : per-cluster single-cycle wake pulse
//   status_o       : per-cluster fully-on indication
//   busy_o         : sequencer is in the middle of a sequence
// The master modport is the host/cluster side; the slave modport is the sequencer.
interface chimera_cluster_pwr_seq_if #(
    parameter int unsigned NumClusters = 5
);
    logic [NumClusters-1:0] en_req_i;
    logic [NumClusters-1:0] cluster_idle_i;
    logic [NumClusters-1:0] clk_en_o;
    logic [NumClusters-1:0] cluster_rst_no;
    logic [NumClusters-1:0] wake_o;
    logic [NumClusters-1:0] status_o;
    logic                   busy_o;

    modport master (
        output en_req_i, cluster_idle_i,
        input  clk_en_o, cluster_rst_no, wake_o, status_o, busy_o
    );

    modport slave (
        input  en_req_i, cluster_idle_i,
        output clk_en_o, cluster_rst_no, wake_o, status_o, busy_o
    );
endinterface

// File: rtl/chimera_cluster_pwr_seq.sv
// Shared power-up/power-down sequencer for the external compute clusters.
// One cluster is sequenced at a time, chosen round-robin among clusters whose
// requested state differs from their actual state.
//   Power-up  : clock gate on, hold reset ClkSettleCycles, release reset,
//               wait RstHoldCycles, pulse wake and raise status.
//   Power-down: (only when the cluster reports idle) assert reset, wait
//               RstHoldCycles, then gate the clock and drop status.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   pwr    : request/idle inputs and clk_en/rst_n/wake/status/busy outputs
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned RstHoldCycles   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    chimera_cluster_pwr_seq_if.slave pwr
);
    localparam int unsigned MaxCycles = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles
                                                                            : RstHoldCycles;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);
    localparam int unsigned IdxWidth  = (NumClusters > 1) ? $clog2(NumClusters) : 1;

    localparam logic [CntWidth-1:0] ClkLoad = CntWidth'(ClkSettleCycles - 1);
    localparam logic [CntWidth-1:0] RstLoad = CntWidth'(RstHoldCycles - 1);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumClusters - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] UP_CLK = 2'd1;
    localparam logic [1:0] UP_RST = 2'd2;
    localparam logic [1:0] DN_RST = 2'd3;

    logic [1:0]             state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [IdxWidth-1:0]    idx_q;
    logic [IdxWidth-1:0]    ptr_q;
    logic [NumClusters-1:0] clk_en_q;
    logic [NumClusters-1:0] rst_n_q;
    logic [NumClusters-1:0] wake_q;
    logic [NumClusters-1:0] status_q;

    logic [NumClusters-1:0] up;
    logic [NumClusters-1:0] dn;
    logic [NumClusters-1:0] elig;
    logic                   grant;
    logic                   grant_up;
    logic [IdxWidth-1:0]    grant_idx;
    int unsigned            cand;

    // Round-robin search: walk from ptr upwards, wrapping, first eligible wins.
    always_comb begin
        up        = pwr.en_req_i & ~status_q;
        dn        = ~pwr.en_req_i & status_q & pwr.cluster_idle_i;
        elig      = up | dn;
        grant     = 1'b0;
        grant_up  = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NumClusters; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NumClusters) begin
                cand = cand - NumClusters;
            end
            if (!grant && elig[cand[IdxWidth-1:0]]) begin
                grant     = 1'b1;
                grant_idx = cand[IdxWidth-1:0];
                grant_up  = up[cand[IdxWidth-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            wake_q   <= '0;
            status_q <= '0;
        end else begin
            wake_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        idx_q <= grant_idx;
                        ptr_q <= (grant_idx == LastIdx) ? '0 : grant_idx + IdxWidth'(1);
                        if (grant_up) begin
                            clk_en_q[grant_idx] <= 1'b1;
                            cnt_q               <= ClkLoad;
                            state_q             <= UP_CLK;
                        end else begin
                            rst_n_q[grant_idx] <= 1'b0;
                            cnt_q              <= RstLoad;
                            state_q            <= DN_RST;
                        end
                    end
                end
                UP_CLK: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rst_n_q[idx_q] <= 1'b1;
                        cnt_q          <= RstLoad;
                        state_q        <= UP_RST;
                    end
                end
                UP_RST: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        wake_q[idx_q]   <= 1'b1;
                        status_q[idx_q] <= 1'b1;
                        state_q         <= IDLE;
                    end
                end
                DN_RST: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        clk_en_q[idx_q] <= 1'b0;
                        status_q[idx_q] <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pwr.clk_en_o       = clk_en_q;
    assign pwr.cluster_rst_no = rst_n_q;
    assign pwr.wake_o         = wake_q;
    assign pwr.status_o       = status_q;
    assign pwr.busy_o         = (state_q != IDLE);
endmodule
